data_mem: RTL and testbench

Data memory for the RV32I 5-stage pipeline's MEM stage. It serves loads and stores from the ALU-computed address in the EX/MEM register. Its combinational read result drives `dm_data_mem` into the MEM/WB pipeline register. It is word-organised, with byte/half/word access, sign/zero extension, misalignment detection and a sticky fault flag.

---
 rtl/data_mem.sv | 148 ++++++++++++++
 tb/tb_data_mem.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// RV32I MEM-stage data memory: word-organised array with byte/half/word loads and stores,
// sign/zero extension, misalignment detection and a sticky fault flag.
module data_mem #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_mem,
    input  logic [31:0] wdata_mem,
    input  logic        load_mem,
    input  logic        store_mem,
    input  logic [2:0]  funct3_mem,
    output logic [31:0] dm_data_mem,
    output logic        misalign_mem,
    output logic        fault
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem_r [DEPTH];
    logic             fault_r;
    logic [IDX_W-1:0] idx_s;
    logic [1:0]       off_s;
    logic             ld_legal_s;
    logic             st_legal_s;
    logic             mis_s;
    logic             we_s;
    logic [3:0]       be_s;
    logic [31:0]      wlane_s;
    logic [31:0]      rd_word_s;
    logic [7:0]       rd_byte_s;
    logic [15:0]      rd_half_s;
    logic             unused_s;

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  lane_mask = 4'b0001 << off;
            3'b001:  lane_mask = 4'b0011 << off;
            3'b010:  lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Replicate narrow store data across all lanes so the lane mask alone selects what lands.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            3'b000:  lane_data = {4{wd[7:0]}};
            3'b001:  lane_data = {2{wd[15:0]}};
            default: lane_data = wd;
        endcase
    endfunction

    assign idx_s    = addr_mem[IDX_W+1:2];
    assign off_s    = addr_mem[1:0];
    assign unused_s = ^addr_mem[31:IDX_W+2];

    // Decode funct3 legality and alignment for the current access.
    always_comb begin
        ld_legal_s = 1'b0;
        st_legal_s = 1'b0;
        mis_s      = 1'b0;
        case (funct3_mem)
            3'b000: begin
                ld_legal_s = 1'b1;
                st_legal_s = 1'b1;
            end
            3'b001: begin
                ld_legal_s = 1'b1;
                st_legal_s = 1'b1;
                mis_s      = off_s[0];
            end
            3'b010: begin
                ld_legal_s = 1'b1;
                st_legal_s = 1'b1;
                mis_s      = (off_s != 2'b00);
            end
            3'b100: begin
                ld_legal_s = 1'b1;
            end
            3'b101: begin
                ld_legal_s = 1'b1;
                mis_s      = off_s[0];
            end
            default: begin
                ld_legal_s = 1'b0;
                st_legal_s = 1'b0;
                mis_s      = 1'b0;
            end
        endcase
    end

    // Illegal encodings never report misalignment, so mis_s is gated by legality per direction.
    assign misalign_mem = mis_s & ((load_mem & ld_legal_s) | (store_mem & st_legal_s));
    assign we_s         = store_mem & st_legal_s & ~mis_s;
    assign be_s         = we_s ? lane_mask(funct3_mem, off_s) : 4'b0000;
    assign wlane_s      = lane_data(funct3_mem, wdata_mem);

    assign rd_word_s = mem_r[idx_s];
    assign rd_byte_s = rd_word_s[{off_s, 3'b000} +: 8];
    assign rd_half_s = off_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];

    // Extended load result; zero whenever no legal aligned load is in progress.
    always_comb begin
        dm_data_mem = 32'h0000_0000;
        if (load_mem && ld_legal_s && !mis_s) begin
            case (funct3_mem)
                3'b000:  dm_data_mem = {{24{rd_byte_s[7]}}, rd_byte_s};
                3'b001:  dm_data_mem = {{16{rd_half_s[15]}}, rd_half_s};
                3'b010:  dm_data_mem = rd_word_s;
                3'b100:  dm_data_mem = {24'h00_0000, rd_byte_s};
                3'b101:  dm_data_mem = {16'h0000, rd_half_s};
                default: dm_data_mem = 32'h0000_0000;
            endcase
        end else begin
            dm_data_mem = 32'h0000_0000;
        end
    end

    // Storage array: cleared by reset, byte-lane writes on the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_r[idx_s][8*k +: 8] <= wlane_s[8*k +: 8];
                end
            end
        end
    end

    // Sticky fault: latches any edge that sees a misaligned access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else if (misalign_mem) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign fault = fault_r;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: byte-addressed reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_mem = 32'h0;
    logic [31:0] wdata_mem = 32'h0;
    logic        load_mem = 1'b0;
    logic        store_mem = 1'b0;
    logic [2:0]  funct3_mem = 3'b000;
    logic [31:0] dm_data_mem;
    logic        misalign_mem;
    logic        fault;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    logic [7:0] mem_m [1024];
    logic       fault_m;

    data_mem #(.DEPTH(256)) dut (
        .clk(clk), .rst(rst), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
        .load_mem(load_mem), .store_mem(store_mem), .funct3_mem(funct3_mem),
        .dm_data_mem(dm_data_mem), .misalign_mem(misalign_mem), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic bit ld_ok(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    endfunction

    function automatic bit st_ok(input logic [2:0] f);
        return (f == 3'd0) || (f == 3'd1) || (f == 3'd2);
    endfunction

    function automatic int size_of(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [2:0] f);
        return (int'(a[9:0]) % size_of(f)) != 0;
    endfunction

    function automatic bit exp_mis();
        return is_mis(addr_mem, funct3_mem) &&
               ((load_mem && ld_ok(funct3_mem)) || (store_mem && st_ok(funct3_mem)));
    endfunction

    function automatic logic [31:0] exp_data();
        logic [31:0] v;
        int a, sz;
        v = 32'h0;
        if (!load_mem || !ld_ok(funct3_mem) || is_mis(addr_mem, funct3_mem)) return 32'h0;
        a  = int'(addr_mem[9:0]);
        sz = size_of(funct3_mem);
        for (int i = 0; i < sz; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
        if (!funct3_mem[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: byte-addressed memory and sticky fault.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem_m[i] <= 8'h00;
            fault_m <= 1'b0;
        end else begin
            if (exp_mis()) fault_m <= 1'b1;
            if (store_mem && st_ok(funct3_mem) && !is_mis(addr_mem, funct3_mem)) begin
                for (int i = 0; i < size_of(funct3_mem); i++)
                    mem_m[int'(addr_mem[9:0]) + i] <= wdata_mem[8*i +: 8];
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model dm_data_mem", dm_data_mem, exp_data());
            chk("model misalign_mem", {31'h0, misalign_mem}, {31'h0, exp_mis()});
            chk("model fault", {31'h0, fault}, {31'h0, fault_m});
        end
    end

    // Apply one access after the next rising edge, then settle just past the falling edge.
    task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        load_mem = ld; store_mem = st; funct3_mem = f3; addr_mem = a; wdata_mem = wd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        op(1'b1, 1'b0, 3'b010, 32'h000, 32'h0);
        chk("reset LW 0x000", dm_data_mem, 32'h0);
        chk("reset fault", {31'h0, fault}, 32'h0);
        op(1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0);
        chk("reset LW 0x3FC", dm_data_mem, 32'h0);
        op(1'b1, 1'b0, 3'b010, 32'h1234, 32'h0);
        chk("reset LW 0x1234", dm_data_mem, 32'h0);

        op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("LW 0x10", dm_data_mem, 32'hDEAD_BEEF);
        op(1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
        chk("LB 0x10", dm_data_mem, 32'hFFFF_FFEF);
        op(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        chk("LBU 0x13", dm_data_mem, 32'h0000_00DE);
        op(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        chk("LH 0x12", dm_data_mem, 32'hFFFF_DEAD);
        op(1'b1, 1'b0, 3'b101, 32'h10, 32'h0);
        chk("LHU 0x10", dm_data_mem, 32'h0000_BEEF);
        op(1'b1, 1'b0, 3'b010, 32'h1010, 32'h0);
        chk("alias LW 0x1010", dm_data_mem, 32'hDEAD_BEEF);

        op(1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
        op(1'b0, 1'b1, 3'b000, 32'h21, 32'hAAAA_AA7F);
        op(1'b0, 1'b1, 3'b001, 32'h22, 32'h5555_8001);
        op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        chk("partial LW 0x20", dm_data_mem, 32'h8001_7F00);

        op(1'b0, 1'b1, 3'b010, 32'h30, 32'h1111_1111);
        chk("aligned SW no misalign", {31'h0, misalign_mem}, 32'h0);
        op(1'b0, 1'b1, 3'b010, 32'h31, 32'h2222_2222);
        chk("SW 0x31 misalign", {31'h0, misalign_mem}, 32'h1);
        chk("fault before edge", {31'h0, fault}, 32'h0);
        op(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
        chk("fault after misaligned SW", {31'h0, fault}, 32'h1);
        chk("LW 0x30 unchanged", dm_data_mem, 32'h1111_1111);
        op(1'b1, 1'b0, 3'b001, 32'h33, 32'h0);
        chk("LH 0x33 data", dm_data_mem, 32'h0);
        chk("LH 0x33 misalign", {31'h0, misalign_mem}, 32'h1);

        op(1'b1, 1'b1, 3'b010, 32'h40, 32'h0000_0005);
        chk("ld+st pre-edge data", dm_data_mem, 32'h0);
        op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        chk("ld+st post-edge data", dm_data_mem, 32'h0000_0005);
        op(1'b0, 1'b1, 3'b011, 32'h41, 32'hFFFF_FFFF);
        chk("illegal store misalign", {31'h0, misalign_mem}, 32'h0);
        op(1'b1, 1'b0, 3'b110, 32'h40, 32'h0);
        chk("illegal load data", dm_data_mem, 32'h0);
        op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        chk("word after illegal store", dm_data_mem, 32'h0000_0005);

        // Asynchronous reset lands mid-cycle with a store pending.
        op(1'b0, 1'b1, 3'b010, 32'h50, 32'h0000_CAFE);
        #2 rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        load_mem = 1'b0; store_mem = 1'b1; funct3_mem = 3'b010;
        addr_mem = 32'h54; wdata_mem = 32'h1357_9BDF;
        @(negedge clk);
        #1;
        chk("fault cleared by reset", {31'h0, fault}, 32'h0);
        op(1'b1, 1'b0, 3'b010, 32'h54, 32'h0);
        chk("first store after release", dm_data_mem, 32'h1357_9BDF);
        op(1'b1, 1'b0, 3'b010, 32'h50, 32'h0);
        chk("store under reset dropped", dm_data_mem, 32'h0);
        chk("LW 0x30 cleared by reset", 32'h0, 32'h0 | mem_m[8'h30]);

        op(1'b0, 1'b0, 3'b010, 32'h54, 32'h0);
        chk("idle data", dm_data_mem, 32'h0);

        @(posedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
